key_debounce: RTL

Per-key synchronizer and debouncer for the board pushbuttons. It sits directly upstream of the KEY parallel-input port: raw, asynchronous, bouncing, active-low button pins enter here, and glitch-free, clock-synchronous active-low levels leave on `key_clean` to drive the port's `in_port`. One-cycle press and release strobes are also provided for fabric logic that does not go through the processor.

---
 rtl/key_debounce.sv | 53 +++++
 1 files changed

// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer and counter debouncer for active-low pushbuttons.
// Each lane accepts a new level only after it has persisted for DEBOUNCE_CYCLES edges.
module key_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_clean,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt [WIDTH];

    // A lane is qualifying whenever s2 disagrees with key_clean; agreement clears the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= '1;
            s2          <= '1;
            key_clean   <= '1;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= key_raw;
            s2 <= s1;
            for (int i = 0; i < int'(WIDTH); i++) begin
                key_press[i]   <= 1'b0;
                key_release[i] <= 1'b0;
                if (s2[i] == key_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    key_clean[i]   <= s2[i];
                    cnt[i]         <= '0;
                    key_press[i]   <= ~s2[i];
                    key_release[i] <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule
